ps2_keycode_rx: RTL

PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

---
 rtl/ps2_keycode_rx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the keyboard lines, decodes
// 11-bit frames (start, 8 data LSB-first, odd parity, stop) and keeps the last two
// valid scan codes in xkey. Receive only; the PS/2 lines are never driven.
module ps2_keycode_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] xkey,
    output logic        key_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    localparam logic [3:0]  FiltLast = 4'(FILTER_LEN - 1);
    localparam logic [15:0] TmoLimit = 16'(TIMEOUT_CYCLES);

    logic [1:0]  clk_sync_q, clk_sync_d;
    logic [1:0]  data_sync_q, data_sync_d;
    logic        filt_q, filt_d;
    logic [3:0]  filt_cnt_q, filt_cnt_d;
    logic [1:0]  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic [15:0] tmo_q, tmo_d;
    logic [15:0] xkey_q, xkey_d;
    logic        key_valid_q, key_valid_d;
    logic        frame_err_q, frame_err_d;

    logic        clk_s;
    logic        data_s;
    logic        fall;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // Two-flop synchronizers and clock glitch filter
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        filt_d      = filt_q;
        filt_cnt_d  = 4'd0;
        if (clk_s != filt_q) begin
            // Counts consecutive samples disagreeing with the filtered level
            if (filt_cnt_q == FiltLast) begin
                filt_d     = clk_s;
                filt_cnt_d = 4'd0;
            end else begin
                filt_cnt_d = filt_cnt_q + 4'd1;
            end
        end
    end

    // Falling edge of the filtered clock, visible in the cycle the filter switches
    assign fall = filt_q & ~filt_d;

    // Frame decoder, timeout and output pulse generation
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        xkey_d      = xkey_q;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == IDLE || fall) begin
            tmo_d = 16'd0;
        end else begin
            tmo_d = tmo_q + 16'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (fall && !data_s) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                    shift_d   = 8'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_d = data_s;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (data_s && (^{shift_q, parity_q})) begin
                        xkey_d      = {xkey_q[7:0], shift_q};
                        key_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A falling edge in the same cycle takes precedence over the timeout
        if (state_q != IDLE && !fall && tmo_q == TmoLimit) begin
            state_d     = IDLE;
            bit_cnt_d   = 3'd0;
            shift_d     = 8'd0;
            frame_err_d = 1'b1;
        end
    end

    // State registers; line-side flops reset to the idle-high level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_cnt_q  <= 4'd0;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            parity_q    <= 1'b0;
            tmo_q       <= 16'd0;
            xkey_q      <= 16'd0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            xkey_q      <= xkey_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign xkey      = xkey_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule
